seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the displayed hex value from a multiplexed, active-low
//   7-segment scan. A digit is accepted once its anode has stayed the same
//   for STABLE_CYCLES clocks. A frame is published once all eight digits
//   have been seen.
//
// Ports
//   clk   : system clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   AN    : [7:0] anode select, active-low, one-hot when a digit is driven
//   SEG   : [6:0] segments, active-low, SEG[0]=a .. SEG[6]=g
//   word  : [31:0] captured frame, digit i at word[4i+3:4i]
//   blank : [7:0] per-digit flag, all segments off
//   bad   : [7:0] per-digit flag, unrecognised glyph
//   valid : one-cycle pulse when word/blank/bad update
//   err   : [1:0] err[0] = last frame had a bad digit, err[1] = timeout
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [6:0]  SEG,
    output logic [31:0] word,
    output logic [7:0]  blank,
    output logic [7:0]  bad,
    output logic        valid,
    output logic [1:0]  err
);

    localparam int unsigned DW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]    an_q, an_d, an_prev_q, an_prev_d;
    logic [6:0]    seg_q, seg_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    seen_q, seen_d;
    logic [31:0]   sh_word_q, sh_word_d;
    logic [7:0]    sh_blank_q, sh_blank_d;
    logic [7:0]    sh_bad_q, sh_bad_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    blank_q, blank_d;
    logic [7:0]    bad_q, bad_d;
    logic          valid_q, valid_d;
    logic [1:0]    err_q, err_d;

    logic [7:0] an_low;
    logic       one_hot;
    logic       accept;
    logic       timeout;
    logic [6:0] pat;
    logic [3:0] dec_nib;
    logic       dec_blank;
    logic       dec_bad;

    // Glyph decoder on the registered segments (active-high pattern).
    always_comb begin
        pat       = ~seg_q;
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (pat)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        an_d      = AN;
        seg_d     = SEG;
        an_prev_d = an_q;

        an_low  = ~an_q;
        one_hot = (an_low != 8'h00) && ((an_low & (an_low - 8'h01)) == 8'h00);

        // Dwell saturates at STABLE_CYCLES so a long hold accepts only once.
        dwell_d = '0;
        accept  = 1'b0;
        if (one_hot && (an_q == an_prev_q)) begin
            if (dwell_q < DW'(STABLE_CYCLES)) begin
                dwell_d = dwell_q + DW'(1);
            end else begin
                dwell_d = dwell_q;
            end
            if (dwell_q == DW'(STABLE_CYCLES - 1)) begin
                accept = 1'b1;
            end
        end

        // Timeout fires on the single clock the counter reaches its limit;
        // an acceptance in that clock clears the counter instead.
        timeout = 1'b0;
        if (accept) begin
            to_d = '0;
        end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TW'(1);
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end
        end

        sh_word_d  = sh_word_q;
        sh_blank_d = sh_blank_q;
        sh_bad_d   = sh_bad_q;
        seen_d     = seen_q;
        word_d     = word_q;
        blank_d    = blank_q;
        bad_d      = bad_q;
        valid_d    = 1'b0;
        err_d      = err_q;

        // Frame copy uses the shadow as it stood before this clock, so an
        // acceptance in the same clock lands in the next frame.
        if (seen_q == 8'hFF) begin
            word_d  = sh_word_q;
            blank_d = sh_blank_q;
            bad_d   = sh_bad_q;
            valid_d = 1'b1;
            err_d   = {1'b0, |sh_bad_q};
            seen_d  = '0;
        end

        if (timeout) begin
            err_d[1] = 1'b1;
            seen_d   = '0;
        end

        if (accept) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (an_low[i]) begin
                    sh_word_d[4*i +: 4] = dec_nib;
                    sh_blank_d[i]       = dec_blank;
                    sh_bad_d[i]         = dec_bad;
                end
            end
            seen_d = seen_d | an_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q       <= 8'hFF;
            an_prev_q  <= 8'hFF;
            seg_q      <= '0;
            dwell_q    <= '0;
            to_q       <= '0;
            seen_q     <= '0;
            sh_word_q  <= '0;
            sh_blank_q <= '0;
            sh_bad_q   <= '0;
            word_q     <= '0;
            blank_q    <= '0;
            bad_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            an_q       <= an_d;
            an_prev_q  <= an_prev_d;
            seg_q      <= seg_d;
            dwell_q    <= dwell_d;
            to_q       <= to_d;
            seen_q     <= seen_d;
            sh_word_q  <= sh_word_d;
            sh_blank_q <= sh_blank_d;
            sh_bad_q   <= sh_bad_d;
            word_q     <= word_d;
            blank_q    <= blank_d;
            bad_q      <= bad_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign word  = word_q;
    assign blank = blank_q;
    assign bad   = bad_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic [31:0] word;
    logic [7:0]  blank;
    logic [7:0]  bad;
    logic        valid;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk   (clk),
        .rst   (rst),
        .AN    (AN),
        .SEG   (SEG),
        .word  (word),
        .blank (blank),
        .bad   (bad),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) vcount++;
    end

    typedef struct {
        logic [6:0] pat;
        logic [3:0] nib;
        logic       blk;
        logic       bd;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
            4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
            4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
            4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
        endcase
        return g;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive digit idx with active-high pattern pat for n clocks.
    task automatic show(input int unsigned idx, input logic [6:0] pat, input int unsigned n);
        logic [7:0] a;
        a = '0;
        a[idx] = 1'b1;
        AN  = ~a;
        SEG = ~pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_nibs(input logic [31:0] nibs);
        for (int unsigned i = 0; i < 8; i++) begin
            show(i, glyph(nibs[4*i +: 4]), 16);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] w, input logic [7:0] bl,
                                 input logic [7:0] bd, input logic [1:0] e, input int nv);
        chk({tag, "_valid_count"}, vcount, nv);
        chk({tag, "_word"}, word, w);
        chk({tag, "_blank"}, {24'h0, blank}, {24'h0, bl});
        chk({tag, "_bad"}, {24'h0, bad}, {24'h0, bd});
        chk({tag, "_err"}, {30'h0, err}, {30'h0, e});
    endtask

    initial begin
        logic [7:0] exp_bad;

        // Decode table: three frames of eight digits.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{glyph(4'(i + 1)), 4'(i + 1), 1'b0, 1'b0};
        end
        vecs[8]  = '{7'h6F, 4'h9, 1'b0, 1'b0};
        vecs[9]  = '{7'h77, 4'hA, 1'b0, 1'b0};
        vecs[10] = '{7'h7C, 4'hB, 1'b0, 1'b0};
        vecs[11] = '{7'h39, 4'hC, 1'b0, 1'b0};
        vecs[12] = '{7'h5E, 4'hD, 1'b0, 1'b0};
        vecs[13] = '{7'h79, 4'hE, 1'b0, 1'b0};
        vecs[14] = '{7'h71, 4'hF, 1'b0, 1'b0};
        vecs[15] = '{7'h3F, 4'h0, 1'b0, 1'b0};
        vecs[16] = '{7'h00, 4'h0, 1'b1, 1'b0};
        vecs[17] = '{7'h01, 4'h0, 1'b0, 1'b1};
        vecs[18] = '{7'h7F, 4'h8, 1'b0, 1'b0};
        vecs[19] = '{7'h7E, 4'h0, 1'b0, 1'b1};
        vecs[20] = '{7'h40, 4'h0, 1'b0, 1'b1};
        vecs[21] = '{7'h3F, 4'h0, 1'b0, 1'b0};
        vecs[22] = '{7'h00, 4'h0, 1'b1, 1'b0};
        vecs[23] = '{7'h77, 4'hA, 1'b0, 1'b0};

        rst = 1'b1;
        AN  = 8'hFF;
        SEG = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 32'h0, 8'h00, 8'h00, 2'b00, 0);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        rst = 1'b0;

        // Table-driven frames.
        for (int f = 0; f < 3; f++) begin
            vcount  = 0;
            exp_bad = '0;
            for (int i = 0; i < 8; i++) begin
                show(i, vecs[8*f + i].pat, 16);
                exp_bad[i] = vecs[8*f + i].bd;
            end
            chk($sformatf("frame%0d_valid_count", f), vcount, 1);
            chk($sformatf("frame%0d_err", f), {30'h0, err}, {31'h0, |exp_bad});
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("frame%0d_nib%0d", f, i), {28'h0, word[4*i +: 4]},
                    {28'h0, vecs[8*f + i].nib});
                chk($sformatf("frame%0d_blank%0d", f, i), {31'h0, blank[i]},
                    {31'h0, vecs[8*f + i].blk});
                chk($sformatf("frame%0d_bad%0d", f, i), {31'h0, bad[i]},
                    {31'h0, vecs[8*f + i].bd});
            end
            if (f == 0) begin
                check_outputs("basic_scan", 32'h87654321, 8'h00, 8'h00, 2'b00, 1);
            end
        end

        // Bad glyph on digit 2, blank on digit 5.
        vcount = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i == 2)      show(i, 7'h01, 16);
            else if (i == 5) show(i, 7'h00, 16);
            else             show(i, glyph(4'(i + 1)), 16);
        end
        check_outputs("bad_blank", 32'h87054021, 8'h20, 8'h04, 2'b01, 1);

        // Digit 3 revisited before frame end: newest value wins.
        vcount = 0;
        show(0, glyph(4'h0), 16);
        show(1, glyph(4'h1), 16);
        show(2, glyph(4'h2), 16);
        show(3, glyph(4'h9), 16);
        show(4, glyph(4'h4), 16);
        show(5, glyph(4'h5), 16);
        show(3, glyph(4'hA), 16);
        show(6, glyph(4'h6), 16);
        show(7, glyph(4'h7), 16);
        check_outputs("overwrite", 32'h7654A210, 8'h00, 8'h00, 2'b00, 1);

        // Two anodes low mid-scan: ignored, no error.
        vcount = 0;
        for (int unsigned i = 0; i < 4; i++) show(i, glyph(4'(2 * i)), 16);
        AN  = 8'hFC;
        SEG = ~glyph(4'h3);
        repeat (50) @(posedge clk);
        #1;
        chk("multi_low_no_valid", vcount, 0);
        chk("multi_low_err", {30'h0, err}, 32'h0);
        for (int unsigned i = 4; i < 8; i++) show(i, glyph(4'(2 * i)), 16);
        check_outputs("multi_low_resume", 32'hECA86420, 8'h00, 8'h00, 2'b00, 1);

        // Reset in mid-frame discards the partial frame.
        vcount = 0;
        for (int unsigned i = 0; i < 5; i++) show(i, glyph(4'(i + 3)), 16);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("midreset", 32'h0, 8'h00, 8'h00, 2'b00, 0);
        chk("midreset_valid", {31'h0, valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        AN  = 8'hFF;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_no_valid", vcount, 0);
        scan_nibs(32'h89ABCDEF);
        check_outputs("post_reset_scan", 32'h89ABCDEF, 8'h00, 8'h00, 2'b00, 1);

        // Short dwell (3 clocks) never accepts; timeout after 1024 idle clocks.
        vcount = 0;
        for (int s = 0; s < 100; s++) begin
            for (int unsigned i = 0; i < 8; i++) show(i, glyph(4'(i)), 3);
            if (s == 39) chk("short_dwell_err_early", {30'h0, err}, 32'h0);
        end
        check_outputs("short_dwell", 32'h89ABCDEF, 8'h00, 8'h00, 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
